// File: rtl/edge_pkg.sv
// Shared definitions for the edge pulse generator.
//   PULSE_CYCLES_MAX : upper bound on the stretch length
//   edge_mode_e      : software-visible mode encoding (bit0 = rise, bit1 = fall)
//   cnt_width()      : stretch counter width for a given pulse length
package edge_pkg;

  localparam int PULSE_CYCLES_MAX = 255;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  // The counter only has to hold PULSE_CYCLES-1; keep at least one bit so
  // the 1-cycle configuration still elaborates cleanly.
  function automatic int cnt_width(input int pulse_cycles);
    if (pulse_cycles <= 1) return 1;
    return $clog2(pulse_cycles);
  endfunction

endpackage

// File: rtl/edge_pulse_gen_if.sv
// Bundle of the per-channel control inputs and status outputs.
//   master : drives signal_in / rise_en / fall_en / flag_clr, reads the status
//   slave  : the edge_pulse_gen side
interface edge_pulse_gen_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] signal_in;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] flag_clr;
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] edge_rise;
  logic [WIDTH-1:0] edge_flag;

  modport master (
    output signal_in, rise_en, fall_en, flag_clr,
    input  edge_pulse, edge_rise, edge_flag
  );

  modport slave (
    input  signal_in, rise_en, fall_en, flag_clr,
    output edge_pulse, edge_rise, edge_flag
  );
endinterface

// File: rtl/edge_pulse_gen_chan.sv
// Single channel: edge detector, pulse stretcher and sticky event flag.
//   clk, rst_n   : clock, asynchronous active-low reset
//   armed_i      : detection enable; low during the cycle(s) that load prev
//   sig_i        : monitored signal (already synchronous)
//   rise_en_i    : accept 0->1 transitions
//   fall_en_i    : accept 1->0 transitions
//   flag_clr_i   : clear strobe for flag_o
//   pulse_o      : stretched pulse, PULSE_CYCLES cycles high per hit
//   rise_o       : polarity of the most recent accepted edge (1 = rising)
//   flag_o       : sticky "edge seen since last clear"
module edge_pulse_gen_chan
  import edge_pkg::*;
#(
  parameter int PULSE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic armed_i,
  input  logic sig_i,
  input  logic rise_en_i,
  input  logic fall_en_i,
  input  logic flag_clr_i,
  output logic pulse_o,
  output logic rise_o,
  output logic flag_o
);

  localparam int CNT_W = cnt_width(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PULSE_CYCLES - 1);

  logic             prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             rise_q, rise_d;
  logic             flag_q, flag_d;
  logic             rise_hit, fall_hit, hit;

  always_comb begin
    rise_hit = armed_i & ~prev_q & sig_i & rise_en_i;
    fall_hit = armed_i & prev_q & ~sig_i & fall_en_i;
    hit      = rise_hit | fall_hit;

    cnt_d   = cnt_q;
    pulse_d = pulse_q;
    rise_d  = rise_q;
    if (hit) begin
      // A hit while stretching simply reloads, so merged pulses have no gap.
      cnt_d   = RELOAD;
      pulse_d = 1'b1;
      rise_d  = rise_hit;
    end else if (cnt_q != '0) begin
      cnt_d   = cnt_q - 1'b1;
      pulse_d = 1'b1;
    end else begin
      pulse_d = 1'b0;
    end

    // Set has priority over clear so a coincident event is never lost.
    flag_d = hit | (flag_q & ~flag_clr_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      rise_q  <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      prev_q  <= sig_i;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      rise_q  <= rise_d;
      flag_q  <= flag_d;
    end
  end

  assign pulse_o = pulse_q;
  assign rise_o  = rise_q;
  assign flag_o  = flag_q;

endmodule

// File: rtl/edge_pulse_gen.sv
// Multi-channel edge detector with programmable pulse stretch and sticky flags.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : edge_pulse_gen_if.slave carrying signal_in, rise_en, fall_en,
//                flag_clr (inputs) and edge_pulse, edge_rise, edge_flag (outputs)
// Build option EDGE_PULSE_GEN_SYNC_EN: adds a 2-flop synchroniser per channel
// in front of detection (3-cycle latency, arming delayed by 2 cycles).
module edge_pulse_gen
  import edge_pkg::*;
#(
  parameter int WIDTH        = 1,
  parameter int PULSE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  edge_pulse_gen_if.slave bus
);

  generate
    if (PULSE_CYCLES < 1 || PULSE_CYCLES > PULSE_CYCLES_MAX) begin : g_bad_pulse_cycles
      $error("edge_pulse_gen: PULSE_CYCLES must be in 1..%0d", PULSE_CYCLES_MAX);
    end
  endgenerate

  logic [WIDTH-1:0] sig_det;

`ifdef EDGE_PULSE_GEN_SYNC_EN
  // prev must load the first synchronised sample, which reaches sync2_q on
  // the second edge after release, so arming completes on the third.
  localparam logic [1:0] ARM_EDGES = 2'd3;

  logic [WIDTH-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.signal_in;
      sync2_q <= sync1_q;
    end
  end

  assign sig_det = sync2_q;
`else
  localparam logic [1:0] ARM_EDGES = 2'd1;

  assign sig_det = bus.signal_in;
`endif

  // Edges seen since release; detection is held off until prev holds a real
  // sample, so a level held across reset cannot look like an edge.
  logic [1:0] arm_cnt_q;
  logic       armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_cnt_q <= 2'd0;
    end else if (arm_cnt_q != ARM_EDGES) begin
      arm_cnt_q <= arm_cnt_q + 2'd1;
    end
  end

  assign armed = (arm_cnt_q == ARM_EDGES);

  logic [WIDTH-1:0] pulse_w, rise_w, flag_w;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
      edge_pulse_gen_chan #(
        .PULSE_CYCLES (PULSE_CYCLES)
      ) u_chan (
        .clk        (clk),
        .rst_n      (rst_n),
        .armed_i    (armed),
        .sig_i      (sig_det[gi]),
        .rise_en_i  (bus.rise_en[gi]),
        .fall_en_i  (bus.fall_en[gi]),
        .flag_clr_i (bus.flag_clr[gi]),
        .pulse_o    (pulse_w[gi]),
        .rise_o     (rise_w[gi]),
        .flag_o     (flag_w[gi])
      );
    end
  endgenerate

  assign bus.edge_pulse = pulse_w;
  assign bus.edge_rise  = rise_w;
  assign bus.edge_flag  = flag_w;

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Directed bench: two 4-channel instances sharing stimulus, one with
// PULSE_CYCLES=1 (legacy pulse) and one with PULSE_CYCLES=4 (stretch/retrigger).
module tb_edge_pulse_gen;

`ifdef EDGE_PULSE_GEN_SYNC_EN
  localparam int LAT = 3;
  localparam int ARM = 3;
`else
  localparam int LAT = 1;
  localparam int ARM = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sig, ren, fen, fclr;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  edge_pulse_gen_if #(.WIDTH(4)) if1 ();
  edge_pulse_gen_if #(.WIDTH(4)) if4 ();

  assign if1.signal_in = sig;
  assign if1.rise_en   = ren;
  assign if1.fall_en   = fen;
  assign if1.flag_clr  = fclr;
  assign if4.signal_in = sig;
  assign if4.rise_en   = ren;
  assign if4.fall_en   = fen;
  assign if4.flag_clr  = fclr;

  edge_pulse_gen #(.WIDTH(4), .PULSE_CYCLES(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  edge_pulse_gen #(.WIDTH(4), .PULSE_CYCLES(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and step just past the edge before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    sig   = 4'b0010;   // ch1 held high through reset
    ren   = 4'b1111;
    fen   = 4'b0000;
    fclr  = 4'b0000;
    repeat (3) tick();

    // Reset state
    check("rst_pulse1", 32'(if1.edge_pulse), 32'h0);
    check("rst_pulse4", 32'(if4.edge_pulse), 32'h0);
    check("rst_rise",   32'(if1.edge_rise),  32'h0);
    check("rst_flag",   32'(if4.edge_flag),  32'h0);

    // Release with ch1 high: arming must not report an edge
    rst_n = 1'b1;
    for (int t = 1; t <= ARM + 3; t++) begin
      tick();
      check("arm_nopulse1", 32'(if1.edge_pulse), 32'h0);
      check("arm_nopulse4", 32'(if4.edge_pulse), 32'h0);
    end
    check("arm_noflag", 32'(if1.edge_flag), 32'h0);

    // ch0 rising edge: 1-cycle pulse on dut1, 4-cycle pulse on dut4
    sig[0] = 1'b1;
    for (int t = 1; t <= LAT + 5; t++) begin
      tick();
      check("rise0_pulse1", 32'(if1.edge_pulse[0]), 32'(t == LAT));
      check("rise0_pulse4", 32'(if4.edge_pulse[0]), 32'(t >= LAT && t < LAT + 4));
      if (t == LAT) begin
        check("rise0_pol",  32'(if1.edge_rise[0]), 32'h1);
        check("rise0_flag", 32'(if1.edge_flag),    32'h1);
      end
    end

    // Clear ch0 flag
    fclr = 4'b0001;
    tick();
    fclr = 4'b0000;
    check("clr0_flag1", 32'(if1.edge_flag), 32'h0);
    check("clr0_flag4", 32'(if4.edge_flag), 32'h0);

    // ch1 falling edge; ch3 toggles while fully disabled
    fen[1] = 1'b1;
    ren[3] = 1'b0;
    sig[1] = 1'b0;
    sig[3] = 1'b1;
    for (int t = 1; t <= LAT + 1; t++) begin
      tick();
      check("fall1_pulse", 32'(if1.edge_pulse), (t == LAT) ? 32'h2 : 32'h0);
    end
    check("fall1_pol",  32'(if1.edge_rise), 32'h1);   // ch0 keeps its rising polarity
    check("fall1_flag", 32'(if1.edge_flag), 32'h2);
    repeat (6) tick();

    // ch2 both modes: rise then fall two cycles later -> merged pulse on dut4
    fen[2] = 1'b1;
    sig[2] = 1'b1;
    for (int t = 1; t <= LAT + 7; t++) begin
      tick();
      check("both2_pulse4", 32'(if4.edge_pulse[2]), 32'(t >= LAT && t <= LAT + 5));
      check("both2_pulse1", 32'(if1.edge_pulse[2]), 32'(t == LAT || t == LAT + 2));
      if (t >= LAT)
        check("both2_pol4", 32'(if4.edge_rise[2]), 32'(t < LAT + 2));
      if (t == 2) sig[2] = 1'b0;
    end

    // Coincident hit + clear on ch2 (set wins); clear without hit on ch1
    check("pre_clr_flag", 32'(if4.edge_flag), 32'h6);
    sig[2] = 1'b1;
    for (int t = 1; t <= LAT; t++) begin
      if (t == LAT) fclr = 4'b0110;
      tick();
      fclr = 4'b0000;
    end
    check("setwins_flag1", 32'(if1.edge_flag), 32'h4);
    check("setwins_flag4", 32'(if4.edge_flag), 32'h4);
    repeat (6) tick();

    // Reset in the middle of a dut4 pulse on ch0
    fen[0] = 1'b1;
    sig[0] = 1'b0;
    for (int t = 1; t <= LAT + 1; t++) tick();
    check("mid_pulse4", 32'(if4.edge_pulse[0]), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_pulse4", 32'(if4.edge_pulse), 32'h0);
    check("async_flag4",  32'(if4.edge_flag),  32'h0);
    check("async_rise4",  32'(if4.edge_rise),  32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int t = 1; t <= ARM + 2; t++) begin
      tick();
      check("rearm_pulse1", 32'(if1.edge_pulse), 32'h0);
      check("rearm_pulse4", 32'(if4.edge_pulse), 32'h0);
    end

    // Re-armed channel detects normally
    sig[1] = 1'b1;
    for (int t = 1; t <= LAT; t++) begin
      tick();
      check("post_pulse1", 32'(if1.edge_pulse), (t == LAT) ? 32'h2 : 32'h0);
    end
    check("post_flag1", 32'(if1.edge_flag), 32'h2);
    check("post_pol1",  32'(if1.edge_rise), 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_pulse_gen.md
Name: edge_pulse_gen

Overview:
- Multi-channel edge detector, the parametrised successor of the single-mode rising-edge detector in io_circuits.
- Per-channel runtime selection of rising, falling or both edges.
- Output pulse stretched to a programmable number of cycles, plus a sticky per-channel event flag with clear.
- Sits between the button/switch synchronisers and the MMIO/CPU-visible status logic.

Parameters:
- WIDTH, 1, number of independent channels.
- PULSE_CYCLES, 1, length in cycles of each output pulse; legal range 1..255; 0 is illegal and caught by an elaboration-time check.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- signal_in  input  WIDTH  monitored signals, already synchronous to clk unless SYNC_EN is defined.
- rise_en  input  WIDTH  per-channel enable for 0->1 detection.
- fall_en  input  WIDTH  per-channel enable for 1->0 detection.
- flag_clr  input  WIDTH  per-channel clear of edge_flag, single-cycle strobe.
- edge_pulse  output  WIDTH  stretched pulse per channel.
- edge_rise  output  WIDTH  polarity of the most recent accepted edge: 1 = rising, 0 = falling.
- edge_flag  output  WIDTH  sticky "edge seen since last clear".

Behaviour:
- Reset (async assert, sync release): edge_pulse=0, edge_rise=0, edge_flag=0, prev=0, stretch counters=0, armed=0.
- Arming:
  - The first clk edge after rst_n deasserts loads prev <= signal_in and sets armed.
  - No edge is reported on that cycle, so a signal held high through reset never produces a spurious pulse.
- Detection at clk edge k, armed:
  - rise = ~prev & in & rise_en; fall = prev & ~in & fall_en; hit = rise | fall.
  - prev <= in every cycle.
  - rise_en/fall_en are sampled on the same edge as the transition.
- Latency: the output is registered. An input transition visible before edge k drives edge_pulse high from just after edge k (1 cycle).
- Stretch, per channel:
  - On hit: counter <= PULSE_CYCLES-1, edge_pulse <= 1, edge_rise <= rise.
  - Otherwise, if counter>0: counter decrements and edge_pulse stays 1.
  - Otherwise edge_pulse <= 0.
  - High time is exactly PULSE_CYCLES cycles. PULSE_CYCLES=1 gives the legacy 1-cycle pulse.
- Retrigger: a hit while stretching reloads the counter, so the pulse is extended with no low gap, and edge_rise is updated.
- Both modes: a 0->1->0 input produces two hits; their pulses merge if they are closer than PULSE_CYCLES.
- Disabled channel (rise_en=fall_en=0): no hits; a pulse already in progress completes normally.
- edge_flag:
  - Set on hit; cleared by flag_clr.
  - Same-cycle hit and flag_clr: set wins, so no event is lost.
- Channels are fully independent; there is no cross-channel interaction.
- Reset mid-pulse: all outputs drop to 0 immediately and asynchronously; the channel re-arms after release.

Optional Feature:
- Macro: EDGE_PULSE_GEN_SYNC_EN.
- Defined:
  - A 2-flop synchroniser per channel precedes detection; total latency becomes 3 cycles.
  - Synchroniser flops reset to 0.
  - The arming cycle uses the synchronised value, so arming occurs 2 cycles later.
- Undefined: signal_in feeds detection directly, with 1-cycle latency as specified above.

Decomposition:
- Shared header/package edge_pkg:
  - PULSE_CYCLES_MAX = 255.
  - Counter width function: clog2 of PULSE_CYCLES.
  - Mode encoding constants EDGE_NONE/RISE/FALL/BOTH for software-visible use.
- Natural sub-module: edge_pulse_chan, a single-channel detector plus stretch counter plus flag.
  - Top holds the armed bit and the optional synchroniser.
  - Top instantiates WIDTH copies via generate.

Test Plan:
- WIDTH=1, PULSE_CYCLES=1, rise_en=1, fall_en=0. Drive in 0->1 at cycle 10, held high. Expect edge_pulse=1 for cycle 11 only, edge_rise=1, edge_flag=1 until flag_clr.
- in held 1 through reset, released at cycle 5. Expect no pulse ever; a subsequent 1->0 with fall_en=1 pulses once with edge_rise=0.
- PULSE_CYCLES=4, both enabled. Drive in rise at cycle 10 and fall at cycle 12. Expect edge_pulse high for cycles 11..16 continuously (reload at 13), edge_rise=0 from cycle 13.
- WIDTH=4. Channel 2 rise coincides with flag_clr[2]=1. Expect edge_flag[2] stays 1. Channel 0 flag_clr with no hit clears only flag[0].
- PULSE_CYCLES=8. Assert rst_n=0 at cycle 3 of a pulse. Expect edge_pulse=0 immediately, and no pulse in the first cycle after release.
- With EDGE_PULSE_GEN_SYNC_EN defined, PULSE_CYCLES=1. Drive in rise at cycle 20. Expect edge_pulse=1 at cycle 23 only.
